// File: rtl/move_collector_pkg.sv
// move_collector_pkg
// Constants, state encoding and move field layout shared by the move
// collector and the square units.
// A move is 19 bits: [18:12] flag bits, [11:6] from-square, [5:0] to-square.
// Flag bit 18 marks an unused (invalid) slot in a FIFO word.
package move_collector_pkg;

    localparam int NUM_SQ  = 64;
    localparam int SEL_W   = 6;
    localparam int MOVE_W  = 19;
    localparam int SLOTS   = 8;
    localparam int SLOT_W  = 3;
    localparam int WORD_W  = 160;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 1023;
    localparam int WD_W    = 10;

    // Flag bit positions inside a move
    localparam int BIT_INVALID = 18;
    localparam int BIT_PROMOTE = 17;
    localparam int BIT_PAWN    = 16;
    localparam int BIT_PAWN2   = 15;
    localparam int BIT_EP      = 14;
    localparam int BIT_CASTLE  = 13;
    localparam int BIT_CAPTURE = 12;
    localparam int FROM_HI     = 11;
    localparam int FROM_LO     = 6;
    localparam int TO_HI       = 5;
    localparam int TO_LO       = 0;

    typedef logic [MOVE_W-1:0] move_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_WAIT,
        ST_SCAN,
        ST_READ,
        ST_LOAD,
        ST_EMIT,
        ST_FIN
    } state_t;

    // Piece codes, shared with the square units
    typedef enum logic [2:0] {
        PC_NONE,
        PC_PAWN,
        PC_KNIGHT,
        PC_BISHOP,
        PC_ROOK,
        PC_QUEEN,
        PC_KING
    } piece_t;

    // Extract slot k from a packed FIFO word
    function automatic move_t get_slot(input logic [SLOTS*MOVE_W-1:0] w,
                                       input logic [SLOT_W-1:0] k);
        return w[int'(k)*MOVE_W +: MOVE_W];
    endfunction

endpackage

// File: rtl/move_collector_if.sv
// move_collector_if
// Square-array bus plus the outgoing serial move stream.
//   sq_reset  one-cycle reset pulse to all squares/FIFOs
//   sq_done   per-square generation done
//   sq_empty  per-square FIFO empty
//   sq_rden   one-hot FIFO read enable
//   sq_sel    index of the square driving sq_q (external mux)
//   sq_q      muxed FIFO word, valid the cycle after sq_rden
//   mv_data / mv_valid / mv_ready   move stream handshake
// master: the collector; slave: the square array and move consumer.
interface move_collector_if;
    import move_collector_pkg::*;

    logic                sq_reset;
    logic [NUM_SQ-1:0]   sq_done;
    logic [NUM_SQ-1:0]   sq_empty;
    logic [NUM_SQ-1:0]   sq_rden;
    logic [SEL_W-1:0]    sq_sel;
    logic [WORD_W-1:0]   sq_q;
    logic [MOVE_W-1:0]   mv_data;
    logic                mv_valid;
    logic                mv_ready;

    modport master (
        output sq_reset, sq_rden, sq_sel, mv_data, mv_valid,
        input  sq_done, sq_empty, sq_q, mv_ready
    );

    modport slave (
        input  sq_reset, sq_rden, sq_sel, mv_data, mv_valid,
        output sq_done, sq_empty, sq_q, mv_ready
    );

endinterface

// File: rtl/move_collector_slot_picker.sv
// slot_picker
// Combinational lowest-set-bit priority encoder over the slot valid mask.
//   mask  SLOTS-bit valid mask
//   idx   index of the lowest set bit (0 when mask is empty)
//   any   at least one bit set
module slot_picker
    import move_collector_pkg::*;
(
    input  logic [SLOTS-1:0]  mask,
    output logic [SLOT_W-1:0] idx,
    output logic              any
);

    // Scan from the top down so the lowest set bit wins
    always_comb begin
        idx = '0;
        any = |mask;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            if (mask[k]) begin
                idx = SLOT_W'(k);
            end
        end
    end

endmodule

// File: rtl/move_collector.sv
// move_collector
// Sequences one move-generation pass over the 64-square array and drains
// every square's FIFO into one serial valid/ready move stream, emitting
// squares 0..63, FIFO order within a square, slots 0..7 within a word.
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   start           begin a pass (honoured in IDLE and FIN only)
//   bus             square-array bus and move stream (master side)
//   move_count      moves accepted this pass, saturating
//   overflow        sticky, set when move_count would pass its maximum
//   gen_done        high in FIN
//   busy            high in every state except IDLE and FIN
//   err_timeout     (WATCHDOG_EN only) WAIT timed out, sticky until CLR
// Build option: define WATCHDOG_EN to bound the wait for all squares done.
module move_collector
    import move_collector_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    move_collector_if.master  bus,
    output logic [CNT_W-1:0]  move_count,
    output logic              overflow,
    output logic              gen_done,
    output logic              busy
`ifdef WATCHDOG_EN
    ,
    output logic              err_timeout
`endif
);

    state_t                  state, state_nxt;
    logic [SEL_W-1:0]        sel;
    logic [SLOTS*MOVE_W-1:0] word_buf;
    logic [SLOTS-1:0]        mask;
    logic [SLOTS-1:0]        load_mask;
    logic [SLOTS-1:0]        mask_after;
    logic [SLOT_W-1:0]       pick_idx;
    logic                    pick_any;
    logic                    accept;
    logic                    unused_q_hi;

    // Bits above the packed slots carry nothing
    assign unused_q_hi = ^bus.sq_q[WORD_W-1:SLOTS*MOVE_W];

    slot_picker u_picker (
        .mask (mask),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign accept     = (state == ST_EMIT) && bus.mv_ready;
    assign mask_after = mask & ~(SLOTS'(1) << pick_idx);

    // A slot is valid when its invalid flag is clear
    always_comb begin
        load_mask = '0;
        for (int k = 0; k < SLOTS; k++) begin
            load_mask[k] = ~bus.sq_q[k*MOVE_W + BIT_INVALID];
        end
    end

`ifdef WATCHDOG_EN
    logic [WD_W-1:0] wd_cnt;

    // Watchdog counts WAIT cycles while any square is still busy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else if (state == ST_CLR) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else if (state == ST_WAIT && !(&bus.sq_done)) begin
            if (wd_cnt == WD_W'(TIMEOUT)) begin
                err_timeout <= 1'b1;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_CLR;
            ST_CLR:  state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (&bus.sq_done) begin
                    state_nxt = ST_SCAN;
                end
`ifdef WATCHDOG_EN
                else if (wd_cnt == WD_W'(TIMEOUT)) begin
                    state_nxt = ST_FIN;
                end
`endif
            end
            ST_SCAN: begin
                if (!bus.sq_empty[sel]) begin
                    state_nxt = ST_READ;
                end else if (sel == SEL_W'(NUM_SQ - 1)) begin
                    state_nxt = ST_FIN;
                end
            end
            ST_READ: state_nxt = ST_LOAD;
            // A word with no valid slots goes back to re-check the same FIFO
            ST_LOAD: state_nxt = (load_mask == '0) ? ST_SCAN : ST_EMIT;
            ST_EMIT: if (accept && mask_after == '0) state_nxt = ST_SCAN;
            ST_FIN:  if (start) state_nxt = ST_CLR;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: square index, word buffer, slot mask and move counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel        <= '0;
            word_buf   <= '0;
            mask       <= '0;
            move_count <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                ST_CLR: begin
                    move_count <= '0;
                    overflow   <= 1'b0;
                end
                ST_WAIT: sel <= '0;
                ST_SCAN: begin
                    if (bus.sq_empty[sel] && sel != SEL_W'(NUM_SQ - 1)) begin
                        sel <= sel + 1'b1;
                    end
                end
                ST_LOAD: begin
                    word_buf <= bus.sq_q[SLOTS*MOVE_W-1:0];
                    mask     <= load_mask;
                end
                ST_EMIT: begin
                    if (accept) begin
                        mask <= mask_after;
                        if (move_count == '1) begin
                            overflow <= 1'b1;
                        end else begin
                            move_count <= move_count + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from the current state
    always_comb begin
        bus.sq_reset = (state == ST_CLR);
        bus.sq_rden  = (state == ST_READ) ? (NUM_SQ'(1) << sel) : '0;
        bus.sq_sel   = sel;
        bus.mv_valid = (state == ST_EMIT) && pick_any;
        bus.mv_data  = (state == ST_EMIT) ? get_slot(word_buf, pick_idx) : '0;
        gen_done     = (state == ST_FIN);
        busy         = (state != ST_IDLE) && (state != ST_FIN);
    end

endmodule

// File: tb/tb_move_collector.sv
// tb_move_collector
// Directed bench for move_collector. A small FIFO model per square serves
// sq_rden with a one-cycle latency; each test task checks its own results.
module tb_move_collector;
    import move_collector_pkg::*;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [CNT_W-1:0] move_count;
    logic             overflow;
    logic             gen_done;
    logic             busy;
`ifdef WATCHDOG_EN
    logic             err_timeout;
`endif

    move_collector_if bus();

    move_collector dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .bus        (bus),
        .move_count (move_count),
        .overflow   (overflow),
        .gen_done   (gen_done),
        .busy       (busy)
`ifdef WATCHDOG_EN
        ,
        .err_timeout(err_timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Square FIFO model
    logic [WORD_W-1:0] mem [NUM_SQ][4];
    int                wrp [NUM_SQ];
    int                rdp [NUM_SQ];
    int                rden_cnt [NUM_SQ];
    logic [WORD_W-1:0] next_q;

    // Observation record
    logic [MOVE_W-1:0] got [300];
    int                n_got;
    int                n_reset;
    int                stab_errs;
    logic              obs_valid, obs_ready, obs_gen_done;
    logic [MOVE_W-1:0] obs_data;

    task automatic refresh_empty();
        for (int i = 0; i < NUM_SQ; i++) begin
            bus.sq_empty[i] = (rdp[i] >= wrp[i]);
        end
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < NUM_SQ; i++) begin
            wrp[i] = 0;
            rdp[i] = 0;
            rden_cnt[i] = 0;
        end
        bus.sq_q = '0;
        next_q   = '0;
        refresh_empty();
    endtask

    task automatic push_word(input int sq, input logic [WORD_W-1:0] w);
        mem[sq][wrp[sq]] = w;
        wrp[sq] = wrp[sq] + 1;
        refresh_empty();
    endtask

    // Eight valid moves {flags=0, from=sq, to=base+slot}; junk above slot 7
    function automatic logic [WORD_W-1:0] full_word(input int sq, input int base);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int k = 0; k < SLOTS; k++) begin
            w[k*MOVE_W +: MOVE_W] = {7'h00, 6'(sq), 6'(base + k)};
        end
        w[WORD_W-1:SLOTS*MOVE_W] = 8'hA5;
        return w;
    endfunction

    // One clock: observe at negedge, serve reads, update FIFO output after posedge
    task automatic cycle();
        @(negedge clk);
        obs_valid    = bus.mv_valid;
        obs_ready    = bus.mv_ready;
        obs_data     = bus.mv_data;
        obs_gen_done = gen_done;
        if (bus.mv_valid && bus.mv_ready && n_got < 300) begin
            got[n_got] = bus.mv_data;
            n_got = n_got + 1;
        end
        if (bus.sq_reset) n_reset = n_reset + 1;
        for (int i = 0; i < NUM_SQ; i++) begin
            if (bus.sq_rden[i]) begin
                rden_cnt[i] = rden_cnt[i] + 1;
                if (rdp[i] < wrp[i]) begin
                    next_q = mem[i][rdp[i]];
                    rdp[i] = rdp[i] + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        bus.sq_q = next_q;
        refresh_empty();
    endtask

    // Run a full pass; returns the number of cycles after the start cycle
    task automatic run_pass(input int budget, input bit toggle, output int k_done);
        logic              pv, pr;
        logic [MOVE_W-1:0] pd;
        bit                done;
        n_got = 0;
        n_reset = 0;
        stab_errs = 0;
        for (int i = 0; i < NUM_SQ; i++) rden_cnt[i] = 0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        k_done = 0;
        done = 0;
        while (!done && k_done < budget) begin
            pv = obs_valid;
            pr = obs_ready;
            pd = obs_data;
            cycle();
            k_done = k_done + 1;
            if (pv && !pr && (!obs_valid || obs_data !== pd)) stab_errs = stab_errs + 1;
            if (toggle) bus.mv_ready = ~bus.mv_ready;
            if (obs_gen_done) done = 1;
        end
        tests++;
        if (!done) begin
            fails++;
            $display("[TB] FAIL pass_timeout: gen_done not seen within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        tests++; if (bus.sq_sel !== '0)   begin fails++; $display("[TB] FAIL reset_sq_sel: got %0h want 0", bus.sq_sel); end
        tests++; if (bus.sq_rden !== '0)  begin fails++; $display("[TB] FAIL reset_sq_rden: got %0h want 0", bus.sq_rden); end
        tests++; if (bus.mv_valid !== 0)  begin fails++; $display("[TB] FAIL reset_mv_valid: got %0b want 0", bus.mv_valid); end
        tests++; if (bus.sq_reset !== 0)  begin fails++; $display("[TB] FAIL reset_sq_reset: got %0b want 0", bus.sq_reset); end
        tests++; if (move_count !== '0)   begin fails++; $display("[TB] FAIL reset_move_count: got %0d want 0", move_count); end
        tests++; if (overflow !== 0)      begin fails++; $display("[TB] FAIL reset_overflow: got %0b want 0", overflow); end
        tests++; if (gen_done !== 0)      begin fails++; $display("[TB] FAIL reset_gen_done: got %0b want 0", gen_done); end
        tests++; if (busy !== 0)          begin fails++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_all_empty();
        int k;
        clear_fifos();
        bus.mv_ready = 1'b1;
        run_pass(200, 0, k);
        // CLR, WAIT, 64 SCAN cycles, then FIN observed
        tests++; if (k !== 67)          begin fails++; $display("[TB] FAIL empty_fin_latency: got %0d want 67", k); end
        tests++; if (n_reset !== 1)     begin fails++; $display("[TB] FAIL empty_sq_reset_pulses: got %0d want 1", n_reset); end
        tests++; if (move_count !== 0)  begin fails++; $display("[TB] FAIL empty_move_count: got %0d want 0", move_count); end
        tests++; if (n_got !== 0)       begin fails++; $display("[TB] FAIL empty_moves: got %0d want 0", n_got); end
        tests++; if (busy !== 0)        begin fails++; $display("[TB] FAIL empty_busy: got %0b want 0", busy); end
    endtask

    task automatic test_sparse_word();
        int k;
        logic [WORD_W-1:0] w;
        clear_fifos();
        w = '1;
        w[0*MOVE_W +: MOVE_W] = 19'h0_0314;  // from 12 to 20
        w[5*MOVE_W +: MOVE_W] = 19'h0_131C;  // capture, from 12 to 28
        push_word(12, w);
        bus.mv_ready = 1'b1;
        run_pass(300, 0, k);
        tests++; if (n_got !== 2)              begin fails++; $display("[TB] FAIL sparse_count: got %0d want 2", n_got); end
        tests++; if (got[0] !== 19'h0_0314)    begin fails++; $display("[TB] FAIL sparse_slot0: got %0h want 00314", got[0]); end
        tests++; if (got[1] !== 19'h0_131C)    begin fails++; $display("[TB] FAIL sparse_slot5: got %0h want 0131c", got[1]); end
        tests++; if (move_count !== 2)         begin fails++; $display("[TB] FAIL sparse_move_count: got %0d want 2", move_count); end
        tests++; if (rden_cnt[12] !== 1)       begin fails++; $display("[TB] FAIL sparse_rden12: got %0d want 1", rden_cnt[12]); end
    endtask

    task automatic test_backpressure();
        int k;
        int bad;
        clear_fifos();
        push_word(3, full_word(3, 0));
        push_word(3, full_word(3, 8));
        bus.mv_ready = 1'b1;
        run_pass(400, 1, k);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (got[i] !== {7'h00, 6'd3, 6'(i)}) bad++;
        end
        tests++; if (n_got !== 16)      begin fails++; $display("[TB] FAIL bp_count: got %0d want 16", n_got); end
        tests++; if (bad !== 0)         begin fails++; $display("[TB] FAIL bp_order: got %0d wrong moves want 0", bad); end
        tests++; if (stab_errs !== 0)   begin fails++; $display("[TB] FAIL bp_stable: got %0d unstable cycles want 0", stab_errs); end
        tests++; if (move_count !== 16) begin fails++; $display("[TB] FAIL bp_move_count: got %0d want 16", move_count); end
        tests++; if (rden_cnt[3] !== 2) begin fails++; $display("[TB] FAIL bp_rden3: got %0d want 2", rden_cnt[3]); end
    endtask

    task automatic test_edge_squares();
        int k;
        logic [WORD_W-1:0] w;
        clear_fifos();
        w = '1;
        w[2*MOVE_W +: MOVE_W] = 19'h0_0008;  // from 0 to 8
        push_word(63, w);
        w = '1;
        w[7*MOVE_W +: MOVE_W] = {7'h00, 6'd63, 6'd55};
        push_word(63, '1);                   // an all-invalid word ahead of the real one
        mem[63][0] = '1;
        mem[63][1] = w;
        mem[0][0]  = '1;
        mem[0][0][2*MOVE_W +: MOVE_W] = 19'h0_0008;
        wrp[0] = 1;
        refresh_empty();
        bus.mv_ready = 1'b1;
        run_pass(400, 0, k);
        tests++; if (n_got !== 2)                        begin fails++; $display("[TB] FAIL edge_count: got %0d want 2", n_got); end
        tests++; if (got[0] !== 19'h0_0008)              begin fails++; $display("[TB] FAIL edge_first_sq0: got %0h want 00008", got[0]); end
        tests++; if (got[1] !== {7'h00, 6'd63, 6'd55})   begin fails++; $display("[TB] FAIL edge_second_sq63: got %0h want 00ff7", got[1]); end
        tests++; if (gen_done !== 1)                     begin fails++; $display("[TB] FAIL edge_gen_done: got %0b want 1", gen_done); end
        tests++; if (rden_cnt[63] !== 2)                 begin fails++; $display("[TB] FAIL edge_rden63: got %0d want 2", rden_cnt[63]); end
    endtask

    task automatic test_overflow();
        int k;
        int bad;
        clear_fifos();
        for (int s = 0; s < 33; s++) push_word(s, full_word(s, 0));
        bus.mv_ready = 1'b1;
        run_pass(3000, 0, k);
        bad = 0;
        for (int i = 0; i < 264; i++) begin
            if (got[i] !== {7'h00, 6'(i / 8), 6'(i % 8)}) bad++;
        end
        tests++; if (n_got !== 264)      begin fails++; $display("[TB] FAIL ovf_emitted: got %0d want 264", n_got); end
        tests++; if (bad !== 0)          begin fails++; $display("[TB] FAIL ovf_order: got %0d wrong moves want 0", bad); end
        tests++; if (move_count !== 255) begin fails++; $display("[TB] FAIL ovf_move_count: got %0d want 255", move_count); end
        tests++; if (overflow !== 1)     begin fails++; $display("[TB] FAIL ovf_flag: got %0b want 1", overflow); end
    endtask

    task automatic test_reset_mid_emit();
        int k;
        clear_fifos();
        push_word(5, full_word(5, 0));
        bus.mv_ready = 1'b1;
        n_got = 0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        k = 0;
        while (n_got < 2 && k < 300) begin
            cycle();
            k++;
        end
        tests++; if (bus.mv_valid !== 1) begin fails++; $display("[TB] FAIL rst_pre_valid: got %0b want 1", bus.mv_valid); end
        tests++; if (move_count !== 2)   begin fails++; $display("[TB] FAIL rst_pre_count: got %0d want 2", move_count); end
        #2 reset_n = 1'b0;
        #1;
        tests++; if (bus.mv_valid !== 0) begin fails++; $display("[TB] FAIL rst_async_valid: got %0b want 0", bus.mv_valid); end
        tests++; if (busy !== 0)         begin fails++; $display("[TB] FAIL rst_async_busy: got %0b want 0", busy); end
        tests++; if (move_count !== 0)   begin fails++; $display("[TB] FAIL rst_async_count: got %0d want 0", move_count); end
        tests++; if (bus.sq_sel !== 0)   begin fails++; $display("[TB] FAIL rst_async_sel: got %0d want 0", bus.sq_sel); end
        #1 reset_n = 1'b1;
        cycle();
        tests++; if (busy !== 0)         begin fails++; $display("[TB] FAIL rst_stays_idle: got %0b want 0", busy); end
    endtask

`ifdef WATCHDOG_EN
    task automatic test_watchdog();
        int k;
        clear_fifos();
        bus.sq_done[40] = 1'b0;
        bus.mv_ready = 1'b1;
        run_pass(3000, 0, k);
        tests++; if (err_timeout !== 1) begin fails++; $display("[TB] FAIL wd_err: got %0b want 1", err_timeout); end
        tests++; if (gen_done !== 1)    begin fails++; $display("[TB] FAIL wd_gen_done: got %0b want 1", gen_done); end
        tests++; if (k < TIMEOUT)       begin fails++; $display("[TB] FAIL wd_early: got %0d cycles want >= %0d", k, TIMEOUT); end
        bus.sq_done = '1;
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        bus.sq_done = '1;
        bus.mv_ready = 1'b0;
        n_got = 0;
        n_reset = 0;
        obs_valid = 0;
        obs_ready = 0;
        obs_data = '0;
        obs_gen_done = 0;
        clear_fifos();
        test_reset();
        test_all_empty();
        test_sparse_word();
        test_backpressure();
        test_edge_squares();
        test_overflow();
        test_reset_mid_emit();
`ifdef WATCHDOG_EN
        test_watchdog();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
